// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: hands one decoded opcode at a time to the ALU,
// holds IMUL for a fixed latency, honours memory backpressure and branch squash.
module alu_issue_ctrl #(
    parameter int OPW     = 10,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [OPW-1:0]   dec_opcode,
    output logic             dec_ready,
    output logic             alu_enable,
    output logic [OPW-1:0]   alu_opcode,
    input  logic             mem_blocked,
    input  logic             branch,
    output logic             exe_valid,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_MULW  = 2'd2;

    localparam logic [OPW-1:0]   IMUL_OP  = OPW'(10'h0F7);
    localparam logic [3:0]       MUL_INIT = 4'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0] state;
    logic [3:0] mul_cnt;
    logic       finishing;
    logic       complete;
    logic       accept;
    logic       is_mul;

    // A branch squashes whatever is in flight, so it also vetoes completion.
    always_comb begin
        finishing = 1'b0;
        if (state == S_ISSUE)
            finishing = !mem_blocked;
        else if (state == S_MULW)
            finishing = (mul_cnt == 4'd0) && !mem_blocked;
        complete  = finishing && !branch;
        dec_ready = !reset && !branch && ((state == S_IDLE) || finishing);
        accept    = dec_valid && dec_ready;
        is_mul    = (dec_opcode == IMUL_OP) && (MUL_LAT > 1);
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            mul_cnt    <= 4'd0;
            alu_enable <= 1'b0;
            alu_opcode <= '0;
            exe_valid  <= 1'b0;
            done_count <= '0;
        end else begin
            exe_valid <= complete;
            if (complete)
                done_count <= done_count + CNT_ONE;

            if (branch && (state != S_IDLE)) begin
                state      <= S_IDLE;
                alu_enable <= 1'b0;
                mul_cnt    <= 4'd0;
            end else if (accept) begin
                alu_opcode <= dec_opcode;
                alu_enable <= 1'b1;
                if (is_mul) begin
                    state   <= S_MULW;
                    mul_cnt <= MUL_INIT;
                end else begin
                    state   <= S_ISSUE;
                    mul_cnt <= 4'd0;
                end
            end else if (complete) begin
                state      <= S_IDLE;
                alu_enable <= 1'b0;
            end else if ((state == S_MULW) && (mul_cnt != 4'd0)) begin
                // Latency counts down even while the memory stage is stalling us.
                mul_cnt <= mul_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against an op-level reference model.
module tb_alu_issue_ctrl;

    localparam int OPW     = 10;
    localparam int MUL_LAT = 3;
    localparam int CNT_W   = 16;
    localparam logic [OPW-1:0] IMUL = 10'h0F7;

    logic             clk;
    logic             reset;
    logic             dec_valid;
    logic [OPW-1:0]   dec_opcode;
    logic             dec_ready;
    logic             alu_enable;
    logic [OPW-1:0]   alu_opcode;
    logic             mem_blocked;
    logic             branch;
    logic             exe_valid;
    logic             busy;
    logic [CNT_W-1:0] done_count;

    alu_issue_ctrl #(.OPW(OPW), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .dec_valid  (dec_valid),
        .dec_opcode (dec_opcode),
        .dec_ready  (dec_ready),
        .alu_enable (alu_enable),
        .alu_opcode (alu_opcode),
        .mem_blocked(mem_blocked),
        .branch     (branch),
        .exe_valid  (exe_valid),
        .busy       (busy),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one op in flight, with the cycles it still has to wait.
    logic             m_busy;
    int               m_left;
    logic             m_enable;
    logic [OPW-1:0]   m_opcode;
    logic             m_exe;
    logic [CNT_W-1:0] m_count;

    logic exp_ready, obs_ready;
    logic [29:0] exp_vec, obs_vec;

    task automatic tick(input logic v, input logic [OPW-1:0] op, input logic mb,
                        input logic br, input logic rst);
        logic done_now;
        logic take;
        dec_valid   = v;
        dec_opcode  = op;
        mem_blocked = mb;
        branch      = br;
        reset       = rst;
        #2;
        done_now  = m_busy && !br && (m_left == 0) && !mb;
        exp_ready = !rst && !br && (!m_busy || ((m_left == 0) && !mb));
        obs_ready = dec_ready;
        take      = v && exp_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            m_busy = 1'b0; m_left = 0; m_enable = 1'b0;
            m_opcode = '0; m_exe = 1'b0; m_count = '0;
        end else begin
            m_exe = done_now;
            if (done_now) m_count = m_count + 1'b1;
            if (m_busy && br) begin
                m_busy = 1'b0; m_enable = 1'b0;
            end else if (take) begin
                m_busy = 1'b1; m_enable = 1'b1; m_opcode = op;
                m_left = (op == IMUL) ? MUL_LAT - 1 : 0;
            end else if (done_now) begin
                m_busy = 1'b0; m_enable = 1'b0;
            end else if (m_busy && m_left > 0) begin
                m_left = m_left - 1;
            end
        end
        exp_vec = {exp_ready, m_enable, m_opcode, m_exe, m_busy, m_count};
        obs_vec = {obs_ready, alu_enable, alu_opcode, exe_valid, busy, done_count};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 10'h001, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (obs_vec !== 30'd0) begin
                n_fail++;
                $display("[TB] FAIL reset_state: got %h expected %h", obs_vec, 30'd0);
            end
        end
    endtask

    task automatic test_single();
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 10'h001, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({obs_ready, alu_enable, alu_opcode} !== {1'b1, 1'b1, 10'h001}) begin
            n_fail++;
            $display("[TB] FAIL single_issue: got %b/%b/%h expected 1/1/001",
                     obs_ready, alu_enable, alu_opcode);
        end
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({exe_valid, alu_enable, busy, done_count} !== {1'b1, 1'b0, 1'b0, 16'd1}) begin
            n_fail++;
            $display("[TB] FAIL single_complete: got exe=%b en=%b busy=%b cnt=%0d expected 1/0/0/1",
                     exe_valid, alu_enable, busy, done_count);
        end
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (exe_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_pulse_width: got exe=%b expected 0", exe_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [OPW-1:0] ops [3] = '{10'h001, 10'h009, 10'h031};
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(i < 3, (i < 3) ? ops[i] : 10'h000, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL b2b_cycle%0d: got %h expected %h", i, obs_vec, exp_vec);
            end
            n_checks++;
            if (obs_ready !== 1'b1 || (i < 3 && alu_opcode !== ops[i]) || exe_valid !== (i > 0)) begin
                n_fail++;
                $display("[TB] FAIL b2b_seq%0d: got rdy=%b op=%h exe=%b", i, obs_ready, alu_opcode, exe_valid);
            end
        end
        n_checks++;
        if (done_count !== 16'd3) begin
            n_fail++;
            $display("[TB] FAIL b2b_count: got %0d expected 3", done_count);
        end
    endtask

    task automatic test_imul();
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, IMUL, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(i < 3, 10'h001, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL imul_cycle%0d: got %h expected %h", i, obs_vec, exp_vec);
            end
            n_checks++;
            if (obs_ready !== (i >= 2)) begin
                n_fail++;
                $display("[TB] FAIL imul_ready%0d: got %b expected %b", i, obs_ready, i >= 2);
            end
        end
        n_checks++;
        if ({exe_valid, done_count, alu_opcode} !== {1'b1, 16'd2, 10'h001}) begin
            n_fail++;
            $display("[TB] FAIL imul_follow: got exe=%b cnt=%0d op=%h expected 1/2/001",
                     exe_valid, done_count, alu_opcode);
        end
    endtask

    task automatic test_stall();
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 10'h088, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 10'h002, i < 4, 1'b0, 1'b0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL stall_cycle%0d: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (i < 4) begin
                n_checks++;
                if ({obs_ready, alu_enable, alu_opcode, exe_valid} !== {1'b0, 1'b1, 10'h088, 1'b0}) begin
                    n_fail++;
                    $display("[TB] FAIL stall_hold%0d: got rdy=%b en=%b op=%h exe=%b",
                             i, obs_ready, alu_enable, alu_opcode, exe_valid);
                end
            end
        end
        n_checks++;
        if ({exe_valid, done_count} !== {1'b1, 16'd1}) begin
            n_fail++;
            $display("[TB] FAIL stall_release: got exe=%b cnt=%0d expected 1/1", exe_valid, done_count);
        end
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_branch();
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, IMUL, 1'b0, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 10'h005, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({obs_ready, alu_enable, busy, exe_valid, alu_opcode} !== {1'b0, 1'b0, 1'b0, 1'b0, IMUL}) begin
            n_fail++;
            $display("[TB] FAIL branch_squash: got rdy=%b en=%b busy=%b exe=%b op=%h",
                     obs_ready, alu_enable, busy, exe_valid, alu_opcode);
        end
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({exe_valid, done_count} !== {1'b0, 16'd0}) begin
            n_fail++;
            $display("[TB] FAIL branch_nocount: got exe=%b cnt=%0d expected 0/0", exe_valid, done_count);
        end
    endtask

    task automatic test_reset_in_stall();
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 10'h088, 1'b0, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 10'h001, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs_vec !== 30'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_in_stall: got %h expected %h", obs_vec, 30'd0);
        end
    endtask

    task automatic test_random();
        logic [OPW-1:0] op;
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            op = ($urandom_range(0, 3) == 0) ? IMUL : OPW'($urandom_range(0, 1023));
            tick($urandom_range(0, 9) < 7, op, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL random_cycle%0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_count_wrap();
        logic [OPW-1:0] op;
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65535; i++) begin
            op = OPW'($urandom_range(0, 1023));
            if (op == IMUL) op = 10'h001;
            tick(1'b1, op, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL wrap_cycle%0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (done_count !== 16'hFFFF) begin
            n_fail++;
            $display("[TB] FAIL count_full: got %h expected ffff", done_count);
        end
        tick(1'b1, 10'h300, 1'b0, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({exe_valid, done_count} !== {1'b1, 16'h0000}) begin
            n_fail++;
            $display("[TB] FAIL count_wrap: got exe=%b cnt=%h expected 1/0000", exe_valid, done_count);
        end
    endtask

    initial begin
        reset = 1'b1; dec_valid = 1'b0; dec_opcode = '0; mem_blocked = 1'b0; branch = 1'b0;
        m_busy = 1'b0; m_left = 0; m_enable = 1'b0; m_opcode = '0; m_exe = 1'b0; m_count = '0;
        $display("[TB] starting alu_issue_ctrl bench");
        test_reset();
        test_single();
        test_back_to_back();
        test_imul();
        test_stall();
        test_branch();
        test_reset_in_stall();
        test_random();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Execute-stage sequencer between decode and the ALU datapath.
- Accepts one decoded opcode per handshake and drives ALU enable/opcode.
- Holds IMUL (0x0F7) for a fixed multi-cycle latency, stalls on memory-stage backpressure, and squashes in-flight work when the ALU reports a branch.
- Counts completed operations for performance debug.

Parameters:
- OPW, 10: opcode width; matches the opcode_t encoding, where 0x100 = 0F-escape and 0x300 = group extension.
- MUL_LAT, 3: ALU cycles an IMUL (opcode 0x0F7) occupies; legal range 1..15.
- CNT_W, 16: width of the completion counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- dec_valid  in  1  decode presents an opcode.
- dec_opcode  in  OPW  decoded opcode.
- dec_ready  out  1  combinational; controller accepts dec_opcode this cycle.
- alu_enable  out  1  registered; ALU evaluates alu_opcode this cycle.
- alu_opcode  out  OPW  registered opcode presented to the ALU.
- mem_blocked  in  1  memory stage cannot take a result; ALU must hold.
- branch  in  1  ALU reports a branch resolved last cycle.
- exe_valid  out  1  registered; one-cycle pulse per completed op.
- busy  out  1  state != IDLE.
- done_count  out  CNT_W  completed-op counter.

Behaviour:
- Reset (synchronous, highest priority):
  - state=IDLE; alu_enable=0, alu_opcode=0, exe_valid=0, done_count=0, mul_cnt=0.
  - dec_ready=0 while reset=1.
- States: IDLE, ISSUE, MULW.
- Accept: a transfer occurs when dec_valid && dec_ready at a posedge.
  - Latch dec_opcode into alu_opcode; set alu_enable=1.
  - If the opcode is 0x0F7, go to MULW with mul_cnt=MUL_LAT-1; otherwise go to ISSUE.
  - If MUL_LAT=1, IMUL behaves like ISSUE.
- Completion condition:
  - ISSUE: completes in the state's cycle when !mem_blocked.
  - MULW: completes when mul_cnt==0 && !mem_blocked.
- Dec_ready:
  - 1 in IDLE.
  - 1 in any completion cycle.
  - Otherwise 0. It is always 0 when branch=1.
- On completion, at the next posedge:
  - exe_valid=1 for exactly one cycle.
  - done_count increments, wrapping from all-ones to 0.
  - If a new op is accepted in the same edge, transition to ISSUE/MULW for that op. Back-to-back single-cycle ops therefore give throughput 1/cycle.
  - Otherwise go to IDLE with alu_enable=0.
- MULW: mul_cnt decrements each cycle while >0, regardless of mem_blocked. At 0 it waits for !mem_blocked.
- Stall: while mem_blocked=1 and not complete, hold state, alu_opcode and alu_enable=1 (ALU keeps its previous value). exe_valid=0.
- Branch squash:
  - If branch=1 in ISSUE or MULW, the in-flight op is discarded: state→IDLE, alu_enable=0, no exe_valid, no count.
  - branch has priority over mem_blocked and over completion.
  - branch=1 in IDLE has no effect other than forcing dec_ready=0.
- Flags/result data never pass through this block; only control does.
- Unsupported opcodes are issued like any single-cycle op.
- Reset mid-MULW or mid-stall returns to the reset values on the next edge; nothing completes.

Test Plan:
- Reset then dec_valid=1 with opcode 0x001 for one cycle, mem_blocked=0 -> alu_enable=1 with alu_opcode=0x001 for 1 cycle; exe_valid pulses 1 cycle later; done_count=1; state IDLE.
- Three back-to-back ops 0x001, 0x009, 0x031 with dec_valid held -> dec_ready stays 1; alu_opcode sequence 0x001, 0x009, 0x031 on consecutive cycles; three consecutive exe_valid pulses; done_count=3.
- IMUL 0x0F7, MUL_LAT=3, followed by 0x001 waiting -> alu_enable high 3 cycles on 0x0F7; dec_ready=0 for the first 2 of them; 0x001 is accepted on the 3rd; exe_valid pulses in order.
- ISSUE of 0x088 with mem_blocked=1 for 4 cycles -> alu_enable and alu_opcode held for 5 cycles; dec_ready=0 for 4 cycles; exactly one exe_valid after mem_blocked drops.
- IMUL in flight, branch=1 on its 2nd cycle -> next edge IDLE, alu_enable=0; no exe_valid; done_count unchanged; dec_ready=0 during the branch cycle.
- done_count preset to 0xFFFF by running 65535 ops, then one more op -> done_count=0x0000. Reset asserted during a stall -> all outputs at reset values next cycle.
